window_scan_ctrl: RTL and testbench
===================================

# window_scan_ctrl

Sequencer for the 9×9 Gaussian window buffer. Walks a 9×9 window over an IMG_W×IMG_H frame in serpentine order (rows left→right, then right→left), requests each new 9-pixel column or row from the SRAM fetch unit, and drives the buffer's `nineXnine_enable`/`gauss_shift` so the buffer always holds the window at (`win_x`, `win_y`). It presents each complete window to the Gaussian stage with a valid/ack handshake, then pulses `frame_done` after the last window.

## Interface
- `IMG_W`, 320: frame width in pixels, at least 9.
- `IMG_H`, 240: frame height in pixels, at least 9.
- `CW`, 9: coordinate width; 2^CW must be at least max(IMG_W, IMG_H).
- `clk` input 1: single clock.
- `n_rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a frame. Ignored unless IDLE.
- `fetch_req` output 1: fetch request. Held with stable address fields until `fetch_valid`.
- `fetch_vertical` output 1: 1 = column of 9 pixels (x, y..y+8) on A..I; 0 = row of 9 pixels (x..x+8, y) on A..I.
- `fetch_x`, `fetch_y` output CW each: fetch start coordinate.
- `fetch_valid` input 1: the 9 pixels on `sram_inA..I` are valid this cycle.
- `nineXnine_enable` output 1: buffer load strobe.
- `gauss_shift` output 2: buffer shift code. 00 = hold, 01 = shift left/new right column, 10 = shift right/new left column, 11 = shift up/new bottom row.
- `window_valid` output 1: buffer holds a complete window at (`win_x`, `win_y`).
- `win_ack` input 1: Gaussian stage consumed the window.
- `win_x`, `win_y` output CW each: top-left of the current window.
- `busy` output 1: high in every state except IDLE.
- `frame_done` output 1: one-cycle pulse after the last window is acknowledged.

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE, `start`:
  - `win_x` = `win_y` = 0, `fill_cnt` = 0, `dir` = right.
  - First fetch: row y=0, x=0, shift 11.
  - Go to FETCH.
- FETCH:
  - `fetch_req` = 1.
  - `nineXnine_enable` = `fetch_valid`, combinational.
  - `gauss_shift` = the registered op code while `nineXnine_enable` is 1, else 00.
  - On `fetch_valid` during fill (`fill_cnt` < 8): increment `fill_cnt`; next fetch is row y=`fill_cnt`+1, x=0, shift 11; stay in FETCH.
  - On `fetch_valid` otherwise: go to PRESENT. The fill loads exactly 9 rows.
- PRESENT: `window_valid` = 1. On `win_ack`, choose the next move:
  - `dir` = right and `win_x` < IMG_W−9: fetch column x=`win_x`+9, y=`win_y`, shift 01; `win_x`++.
  - `dir` = left and `win_x` > 0: fetch column x=`win_x`−1, y=`win_y`, shift 10; `win_x`−−.
  - Row end and `win_y` < IMG_H−9: fetch row x=`win_x`, y=`win_y`+9, shift 11; `win_y`++; toggle `dir`.
  - Row end and `win_y` = IMG_H−9: go to DONE.
- DONE: `frame_done` = 1 for one cycle, then IDLE.
- `win_x`/`win_y` update on the `win_ack` edge, so they already name the window being fetched.
- Windows per frame: (IMG_W−8)·(IMG_H−8).
- Ignored inputs:
  - `fetch_valid` outside FETCH.
  - `win_ack` outside PRESENT.
  - `start` while busy.

## Timing
- Reset values:
  - All outputs 0; `gauss_shift` = 00.
  - State IDLE; `dir` = right; counters 0.
- `fetch_req` rises the cycle after `start` or `win_ack`.
- Fetch latency is unbounded; `fetch_req` and the address are held stable while waiting.
- `nineXnine_enable` is high only in the cycle where FETCH and `fetch_valid` coincide. The buffer captures on that edge.
- `window_valid` rises the cycle after the 9th fill load or the single move load. It stays high until the `win_ack` edge.
- With zero-wait fetch and immediate ack:
  - Fill to first `window_valid`: 10 cycles after `start`.
  - Each subsequent window: 2 cycles.
- Reset mid-operation returns immediately to IDLE. All outputs drop to 0 and no `frame_done` is issued.
- IMG_W = 9: no horizontal moves; each row end goes straight to a shift-up.
- IMG_H = 9: the frame finishes after the first row sweep.

## Structure
- Shared package `canny_pkg` holds:
  - `gauss_shift_t` enum: SHIFT_HOLD=00, SHIFT_LEFT=01, SHIFT_RIGHT=10, SHIFT_UP=11.
  - Constant `WIN = 9`.
  - State enum `scan_state_t`.
- No sub-module: one FSM plus position and fill counters.

## Test plan
- IMG_W=IMG_H=10, zero-wait fetch, immediate ack:
  - 9 fills (rows y=0..8, x=0, shift 11), then windows (0,0),(1,0),(1,1),(0,1).
  - Fetches after the fill: col x=9 shift 01; row y=9 x=1 shift 11; col x=0 shift 10.
  - `frame_done` once, 4 windows.
- IMG_W=12, IMG_H=9: 4 windows, x = 0..3, `win_y` = 0 throughout, no shift 11 after the fill.
- Fetch stall of 5 cycles:
  - `fetch_req`, `fetch_x`, `fetch_y` and `fetch_vertical` stable throughout.
  - `nineXnine_enable` exactly 1 cycle.
- `win_ack` delayed 7 cycles: `window_valid` held 7 cycles and no fetch is issued. A stray `fetch_valid` during PRESENT gives no enable.
- `start` pulsed while busy: no effect; the window sequence is unchanged.
- `n_rst` low during the second window fetch: all outputs 0 asynchronously. A new `start` restarts the fill at (0,0).

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge pipeline blocks.
// Shift codes match the 9x9 buffer's gauss_shift encoding.
package canny_pkg;

    localparam int WIN = 9;

    typedef enum logic [1:0] {
        SHIFT_HOLD  = 2'b00,
        SHIFT_LEFT  = 2'b01,
        SHIFT_RIGHT = 2'b10,
        SHIFT_UP    = 2'b11
    } gauss_shift_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } scan_state_t;

endpackage

// File: rtl/window_scan_ctrl.sv
// Serpentine 9x9 window sequencer: fills the buffer with 9 rows, then moves it one
// column or row per acknowledged window, requesting each new slice from the fetch unit.
module window_scan_ctrl
    import canny_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int CW    = 9
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    output logic          fetch_req,
    output logic          fetch_vertical,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y,
    input  logic          fetch_valid,
    output logic          nineXnine_enable,
    output logic [1:0]    gauss_shift,
    output logic          window_valid,
    input  logic          win_ack,
    output logic [CW-1:0] win_x,
    output logic [CW-1:0] win_y,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [CW-1:0] X_LAST    = CW'(IMG_W - WIN);
    localparam logic [CW-1:0] Y_LAST    = CW'(IMG_H - WIN);
    localparam logic [CW-1:0] WIN_CW    = CW'(WIN);
    localparam logic [3:0]    FILL_LAST = 4'(WIN - 1);

    scan_state_t  state, next_state;
    gauss_shift_t op;
    logic [3:0]   fill_cnt;
    logic         dir_left;
    logic         load, ack, can_right, can_left, can_up;

    assign load      = (state == FETCH) && fetch_valid;
    assign ack       = (state == PRESENT) && win_ack;
    assign can_right = !dir_left && (win_x < X_LAST);
    assign can_left  = dir_left && (win_x != '0);
    assign can_up    = win_y < Y_LAST;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    end

    // fill_cnt sits at FILL_LAST after the fill, so every later fetch is a single move load.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (fetch_valid && fill_cnt == FILL_LAST) next_state = PRESENT;
            PRESENT: if (win_ack) next_state = (can_right || can_left || can_up) ? FETCH : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fill_cnt       <= '0;
            dir_left       <= 1'b0;
            win_x          <= '0;
            win_y          <= '0;
            fetch_x        <= '0;
            fetch_y        <= '0;
            fetch_vertical <= 1'b0;
            op             <= SHIFT_HOLD;
        end else if (state == IDLE && start) begin
            fill_cnt       <= '0;
            dir_left       <= 1'b0;
            win_x          <= '0;
            win_y          <= '0;
            fetch_x        <= '0;
            fetch_y        <= '0;
            fetch_vertical <= 1'b0;
            op             <= SHIFT_UP;
        end else if (load && fill_cnt != FILL_LAST) begin
            fill_cnt <= fill_cnt + 4'd1;
            fetch_y  <= CW'(fill_cnt + 4'd1);
        end else if (ack) begin
            // Position moves on the ack edge so win_x/win_y already name the window being fetched.
            if (can_right) begin
                fetch_x        <= win_x + WIN_CW;
                fetch_y        <= win_y;
                fetch_vertical <= 1'b1;
                op             <= SHIFT_LEFT;
                win_x          <= win_x + 1'b1;
            end else if (can_left) begin
                fetch_x        <= win_x - 1'b1;
                fetch_y        <= win_y;
                fetch_vertical <= 1'b1;
                op             <= SHIFT_RIGHT;
                win_x          <= win_x - 1'b1;
            end else if (can_up) begin
                fetch_x        <= win_x;
                fetch_y        <= win_y + WIN_CW;
                fetch_vertical <= 1'b0;
                op             <= SHIFT_UP;
                win_y          <= win_y + 1'b1;
                dir_left       <= !dir_left;
            end
        end
    end

    // NOTE: every output gets a default first so the decode cannot infer a latch.
    always_comb begin
        fetch_req        = 1'b0;
        nineXnine_enable = 1'b0;
        gauss_shift      = SHIFT_HOLD;
        window_valid     = 1'b0;
        busy             = 1'b1;
        frame_done       = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            FETCH: begin
                fetch_req        = 1'b1;
                nineXnine_enable = fetch_valid;
                gauss_shift      = fetch_valid ? op : SHIFT_HOLD;
            end
            PRESENT: window_valid = 1'b1;
            DONE:    frame_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: a 10x10 instance and a 12x9 instance checked
// against hand-derived fetch and window tables under stalls, slow acks and reset.
module tb_window_scan_ctrl;

    localparam int CW = 9;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic start = 1'b0;
    logic fetch_valid = 1'b0;
    logic win_ack = 1'b0;
    logic sel = 1'b0;  // 0 = 10x10 instance, 1 = 12x9 instance

    logic a_start, a_fv, a_ack, a_req, a_vert, a_en, a_wv, a_busy, a_done;
    logic b_start, b_fv, b_ack, b_req, b_vert, b_en, b_wv, b_busy, b_done;
    logic [CW-1:0] a_fx, a_fy, a_wx, a_wy, b_fx, b_fy, b_wx, b_wy;
    logic [1:0] a_sh, b_sh;

    assign a_start = start & ~sel;
    assign a_fv    = fetch_valid & ~sel;
    assign a_ack   = win_ack & ~sel;
    assign b_start = start & sel;
    assign b_fv    = fetch_valid & sel;
    assign b_ack   = win_ack & sel;

    logic req, vert, en, wv, bsy, done;
    logic [CW-1:0] fx, fy, wx, wy;
    logic [1:0] sh;

    assign req  = sel ? b_req  : a_req;
    assign vert = sel ? b_vert : a_vert;
    assign en   = sel ? b_en   : a_en;
    assign wv   = sel ? b_wv   : a_wv;
    assign bsy  = sel ? b_busy : a_busy;
    assign done = sel ? b_done : a_done;
    assign fx   = sel ? b_fx   : a_fx;
    assign fy   = sel ? b_fy   : a_fy;
    assign wx   = sel ? b_wx   : a_wx;
    assign wy   = sel ? b_wy   : a_wy;
    assign sh   = sel ? b_sh   : a_sh;

    window_scan_ctrl #(.IMG_W(10), .IMG_H(10), .CW(CW)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(a_start),
        .fetch_req(a_req), .fetch_vertical(a_vert), .fetch_x(a_fx), .fetch_y(a_fy),
        .fetch_valid(a_fv), .nineXnine_enable(a_en), .gauss_shift(a_sh),
        .window_valid(a_wv), .win_ack(a_ack), .win_x(a_wx), .win_y(a_wy),
        .busy(a_busy), .frame_done(a_done)
    );

    window_scan_ctrl #(.IMG_W(12), .IMG_H(9), .CW(CW)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(b_start),
        .fetch_req(b_req), .fetch_vertical(b_vert), .fetch_x(b_fx), .fetch_y(b_fy),
        .fetch_valid(b_fv), .nineXnine_enable(b_en), .gauss_shift(b_sh),
        .window_valid(b_wv), .win_ack(b_ack), .win_x(b_wx), .win_y(b_wy),
        .busy(b_busy), .frame_done(b_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pk_f(input int x, input int y, input int v, input int s);
        return (x << 16) | (y << 4) | (v << 2) | s;
    endfunction

    function automatic int pk_w(input int x, input int y);
        return (x << 16) | y;
    endfunction

    int exp_fetch[$];
    int exp_win[$];

    task automatic load_fill;
        exp_fetch.delete();
        exp_win.delete();
        for (int r = 0; r < 9; r++) exp_fetch.push_back(pk_f(0, r, 0, 3));
    endtask

    task automatic load_10x10;
        load_fill();
        exp_fetch.push_back(pk_f(9, 0, 1, 1));
        exp_fetch.push_back(pk_f(1, 9, 0, 3));
        exp_fetch.push_back(pk_f(0, 1, 1, 2));
        exp_win.push_back(pk_w(0, 0));
        exp_win.push_back(pk_w(1, 0));
        exp_win.push_back(pk_w(1, 1));
        exp_win.push_back(pk_w(0, 1));
    endtask

    task automatic load_12x9;
        load_fill();
        exp_fetch.push_back(pk_f(9, 0, 1, 1));
        exp_fetch.push_back(pk_f(10, 0, 1, 1));
        exp_fetch.push_back(pk_f(11, 0, 1, 1));
        for (int x = 0; x < 4; x++) exp_win.push_back(pk_w(x, 0));
    endtask

    // stall: idle cycles before fetch_valid; ack_dly: cycles window_valid is held (1 = immediate)
    task automatic run_frame(input string name, input int stall, input int ack_dly,
                             input bit stray, input bit poke_start);
        int cyc = 0;
        int n_f = 0;
        int n_w = 0;
        int n_done = 0;
        int stall_cnt = 0;
        int ack_cnt = 0;
        int last_rise = 0;
        bit new_fetch = 1'b1;
        bit finished = 1'b0;
        int held = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished && cyc < 2000) begin
            cyc++;
            fetch_valid = 1'b0;
            win_ack = 1'b0;
            if (cyc == 1) check({name, "_busy"}, bsy, 1);
            if (req) begin
                if (new_fetch) begin
                    held = pk_f(fx, fy, vert, 0);
                    new_fetch = 1'b0;
                    stall_cnt = 0;
                end else begin
                    check({name, "_addr_hold"}, pk_f(fx, fy, vert, 0), held);
                end
                fetch_valid = (stall_cnt >= stall);
                stall_cnt++;
            end
            if (wv) begin
                if (ack_cnt == 0) begin
                    if (n_w < exp_win.size()) check({name, "_win_pos"}, pk_w(wx, wy), exp_win[n_w]);
                    else check({name, "_extra_win"}, n_w, exp_win.size());
                    if (n_w == 0) check({name, "_first_lat"}, cyc, 9 * (stall + 1) + 1);
                    else check({name, "_win_gap"}, cyc - last_rise, stall + 1 + ack_dly);
                    last_rise = cyc;
                    n_w++;
                end
                ack_cnt++;
                win_ack = (ack_cnt >= ack_dly);
                fetch_valid = stray;
                check({name, "_req_in_present"}, req, 0);
            end
            if (poke_start && (cyc == 3 || wv)) start = 1'b1;
            #1;
            if (req) begin
                check({name, "_en"}, en, fetch_valid);
                if (en) begin
                    if (n_f < exp_fetch.size()) check({name, "_fetch"}, pk_f(fx, fy, vert, sh), exp_fetch[n_f]);
                    else check({name, "_extra_fetch"}, n_f, exp_fetch.size());
                    n_f++;
                    new_fetch = 1'b1;
                end else begin
                    check({name, "_shift_idle"}, sh, 0);
                end
            end
            if (wv) begin
                check({name, "_stray_en"}, {en, sh}, 3'b000);
                if (win_ack) begin
                    check({name, "_valid_len"}, ack_cnt, ack_dly);
                    ack_cnt = 0;
                end
            end
            if (done) begin
                n_done++;
                finished = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        fetch_valid = 1'b0;
        win_ack = 1'b0;
        check({name, "_finished"}, finished, 1);
        check({name, "_done_cnt"}, n_done, 1);
        check({name, "_n_win"}, n_w, exp_win.size());
        check({name, "_n_fetch"}, n_f, exp_fetch.size());
        check({name, "_done_pulse"}, {done, bsy}, 2'b00);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {req, vert, en, wv, bsy, done, sh}, 8'h00);
        check({name, "_fetch_xy"}, {fx, fy}, '0);
        check({name, "_win_xy"}, {wx, wy}, '0);
    endtask

    // Reset lands while the first move (column x=9) is being fetched.
    task automatic reset_mid;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fetch_valid = 1'b1;
        win_ack = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_pre_state", {req, vert, wx, wy}, {1'b1, 1'b1, 9'd1, 9'd0});
        check("rst_pre_x", fx, 9);
        #1 n_rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        fetch_valid = 1'b0;
        win_ack = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_no_done", {done, bsy}, 2'b00);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        #1 check_all_zero("reset_a");
        sel = 1'b1;
        #1 check_all_zero("reset_b");
        sel = 1'b0;
        n_rst = 1'b1;
        @(posedge clk); #1;

        load_10x10();
        run_frame("basic", 0, 1, 1'b0, 1'b0);
        run_frame("stall", 5, 1, 1'b0, 1'b0);
        run_frame("ack_dly", 0, 7, 1'b1, 1'b0);
        run_frame("busy_start", 0, 1, 1'b0, 1'b1);
        reset_mid();
        run_frame("restart", 0, 1, 1'b0, 1'b0);

        sel = 1'b1;
        load_12x9();
        @(posedge clk); #1;
        run_frame("w12h9", 0, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
